// File: rtl/keypad_entry.sv
// keypad_entry
//   Debounces the raw keypad scanner code on the scan tick, emits one strobe
//   per physical press, and builds a multi-digit hex entry with clear/enter.
//
// Ports
//   clock        system clock
//   reset_n      asynchronous active-low reset
//   tick         one-cycle scan enable; key_code is sampled only when high
//   key_code     raw scanner code, 0-15 key, 16-31 no key
//   press_strobe one-cycle pulse per accepted press
//   press_code   code of the last accepted press (held between presses)
//   entry        digits entered so far, newest digit in [3:0]
//   digit_count  number of digits currently held in entry
//   overflow     sticky, set when a digit arrives with the entry full
//   value        entry captured on the last non-empty enter
//   value_valid  one-cycle pulse when value updates
module keypad_entry #(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int DIGITS         = 4,
    parameter int CLEAR_CODE     = 14,
    parameter int ENTER_CODE     = 15
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           tick,
    input  logic [4:0]                     key_code,
    output logic                           press_strobe,
    output logic [3:0]                     press_code,
    output logic [4*DIGITS-1:0]            entry,
    output logic [$clog2(DIGITS+1)-1:0]    digit_count,
    output logic                           overflow,
    output logic [4*DIGITS-1:0]            value,
    output logic                           value_valid
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [3:0]    DT_C    = 4'(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] DIGITS_C = CW'(DIGITS);
    localparam logic [3:0]    CLR_C   = 4'(CLEAR_CODE);
    localparam logic [3:0]    ENT_C   = 4'(ENTER_CODE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        PRESSED = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cand_q, cand_d;
    logic       accept;

    // Codes 16..31 all mean "no key"; only the low nibble identifies a key.
    logic       none;
    logic [3:0] code;
    logic [3:0] cnt_inc;

    assign none    = key_code[4];
    assign code    = key_code[3:0];
    assign cnt_inc = cnt_q + 4'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        accept  = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!none) begin
                        cand_d  = code;
                        cnt_d   = 4'd1;
                        state_d = CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (!none && code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DT_C) begin
                            state_d = PRESSED;
                            accept  = 1'b1;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    // A key change while held is ignored; only release leaves.
                    if (none) begin
                        cnt_d   = 4'd1;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DT_C) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = PRESSED;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Shift the new digit in at the bottom; the wide concat keeps the slice
    // legal when DIGITS is 1.
    logic [4*DIGITS+3:0] shifted;
    assign shifted = {entry, cand_q};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            press_strobe <= 1'b0;
            press_code   <= '0;
            entry        <= '0;
            digit_count  <= '0;
            overflow     <= 1'b0;
            value        <= '0;
            value_valid  <= 1'b0;
        end else begin
            press_strobe <= accept;
            value_valid  <= 1'b0;
            if (accept) begin
                press_code <= cand_q;
                if (cand_q == CLR_C) begin
                    entry       <= '0;
                    digit_count <= '0;
                    overflow    <= 1'b0;
                end else if (cand_q == ENT_C) begin
                    // An empty entry is not committed.
                    if (digit_count != '0) begin
                        value       <= entry;
                        value_valid <= 1'b1;
                        entry       <= '0;
                        digit_count <= '0;
                        overflow    <= 1'b0;
                    end
                end else if (digit_count < DIGITS_C) begin
                    entry       <= shifted[4*DIGITS-1:0];
                    digit_count <= digit_count + CW'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
module tb_keypad_entry;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0;
    logic [4:0]  key_code = 5'd16;
    logic        press_strobe;
    logic [3:0]  press_code;
    logic [15:0] entry;
    logic [2:0]  digit_count;
    logic        overflow;
    logic [15:0] value;
    logic        value_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] entry;
        logic [2:0]  cnt;
        logic        ovf;
        logic        vv;
        logic [15:0] value;
    } exp_t;

    exp_t exp_q[$];

    keypad_entry #(
        .DEBOUNCE_TICKS(4),
        .DIGITS(4),
        .CLEAR_CODE(14),
        .ENTER_CODE(15)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .tick(tick),
        .key_code(key_code),
        .press_strobe(press_strobe),
        .press_code(press_code),
        .entry(entry),
        .digit_count(digit_count),
        .overflow(overflow),
        .value(value),
        .value_valid(value_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (reset_n && press_strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got code %0d expected no strobe", press_code);
            end else begin
                e = exp_q.pop_front();
                chk("press_code", 32'(press_code), 32'(e.code));
                chk("entry", 32'(entry), 32'(e.entry));
                chk("digit_count", 32'(digit_count), 32'(e.cnt));
                chk("overflow", 32'(overflow), 32'(e.ovf));
                chk("value_valid", 32'(value_valid), 32'(e.vv));
                chk("value", 32'(value), 32'(e.value));
            end
        end else if (reset_n && value_valid) begin
            checks++;
            errors++;
            $display("FAIL stray_value_valid: got 1 expected 0");
        end
    end

    task automatic push(input logic [3:0] c, input logic [15:0] en, input logic [2:0] n,
                        input logic ov, input logic vv, input logic [15:0] v);
        exp_t e;
        e.code = c; e.entry = en; e.cnt = n; e.ovf = ov; e.vv = vv; e.value = v;
        exp_q.push_back(e);
    endtask

    // One scan sample; gap = idle cycles after the tick (0 = back-to-back).
    task automatic samp(input logic [4:0] c, input int gap = 2);
        @(negedge clock);
        key_code = c;
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    // Full press/release; expected response is queued before the accepting tick.
    task automatic press(input logic [4:0] k, input logic [15:0] en, input logic [2:0] n,
                         input logic ov, input logic vv, input logic [15:0] v);
        repeat (3) samp(k);
        push(k[3:0], en, n, ov, vv, v);
        samp(k);
        repeat (4) samp(5'd16);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_strobe"}, 32'(press_strobe), 0);
        chk({tag, "_code"}, 32'(press_code), 0);
        chk({tag, "_entry"}, 32'(entry), 0);
        chk({tag, "_count"}, 32'(digit_count), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_value"}, 32'(value), 0);
        chk({tag, "_vv"}, 32'(value_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Clean press; release uses code 31, which must count as no key.
        repeat (3) samp(5'd5);
        push(4'd5, 16'h0005, 3'd1, 1'b0, 1'b0, 16'h0000);
        samp(5'd5);
        repeat (4) samp(5'd31);

        // Bounce reject, then a clean press of 7.
        samp(5'd7); samp(5'd16); samp(5'd7); samp(5'd7); samp(5'd16);
        repeat (4) @(negedge clock);
        chk("bounce_entry", 32'(entry), 32'h0005);
        press(5'd7, 16'h0057, 3'd2, 1'b0, 1'b0, 16'h0000);

        // Release bounce: one strobe only.
        repeat (3) samp(5'd3);
        push(4'd3, 16'h0573, 3'd3, 1'b0, 1'b0, 16'h0000);
        samp(5'd3);
        samp(5'd16); samp(5'd16); samp(5'd3);
        repeat (4) samp(5'd16);

        // Clear, then entry and enter (back-to-back ticks for one press).
        press(5'd14, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000);
        press(5'd1, 16'h0001, 3'd1, 1'b0, 1'b0, 16'h0000);
        repeat (3) samp(5'd2, 0);
        push(4'd2, 16'h0012, 3'd2, 1'b0, 1'b0, 16'h0000);
        samp(5'd2, 0);
        repeat (4) samp(5'd16, 0);
        press(5'd3, 16'h0123, 3'd3, 1'b0, 1'b0, 16'h0000);
        press(5'd10, 16'h123A, 3'd4, 1'b0, 1'b0, 16'h0000);
        press(5'd15, 16'h0000, 3'd0, 1'b0, 1'b1, 16'h123A);

        // Overflow, clear, empty enter.
        press(5'd1, 16'h0001, 3'd1, 1'b0, 1'b0, 16'h123A);
        press(5'd2, 16'h0012, 3'd2, 1'b0, 1'b0, 16'h123A);
        press(5'd3, 16'h0123, 3'd3, 1'b0, 1'b0, 16'h123A);
        press(5'd4, 16'h1234, 3'd4, 1'b0, 1'b0, 16'h123A);
        press(5'd5, 16'h1234, 3'd4, 1'b1, 1'b0, 16'h123A);
        press(5'd14, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h123A);
        press(5'd15, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h123A);

        // Reset during CONFIRM with 9 held.
        press(5'd6, 16'h0006, 3'd1, 1'b0, 1'b0, 16'h123A);
        samp(5'd9); samp(5'd9);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) samp(5'd9);
        push(4'd9, 16'h0009, 3'd1, 1'b0, 1'b0, 16'h0000);
        samp(5'd9);
        repeat (4) samp(5'd16);

        repeat (5) @(negedge clock);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
Sits directly downstream of the 4x4 keypad scanner and consumes its raw 5-bit key code (0-15 = key, 16 = no key).
- Debounces the code on the scanner's scan tick and emits exactly one strobe per physical press.
- Accumulates digit presses into a multi-digit hex entry register.
- Handles clear and enter keys and presents a latched value to the display/count logic.

Parameters:
DEBOUNCE_TICKS, 4, consecutive matching scan ticks needed to accept a press or a release (legal range 2..15).
DIGITS, 4, maximum hex digits held in the entry register (legal range 1..8).
CLEAR_CODE, 14, key code that clears the entry ('*').
ENTER_CODE, 15, key code that commits the entry ('#').

Ports:
clock  input  1  system clock (CLOCK_50 domain).
reset_n  input  1  asynchronous active-low reset.
tick  input  1  one-cycle scan-rate enable, aligned to the scanner's divided clock; key_code is sampled only when tick=1.
key_code  input  5  raw scanner code; 16 = no key; 17-31 are treated as 16.
press_strobe  output  1  one-cycle pulse per accepted press.
press_code  output  4  code of the last accepted press; valid whenever press_strobe=1, and held until the next press.
entry  output  4*DIGITS  digits entered so far; newest digit in bits [3:0].
digit_count  output  clog2(DIGITS+1)  number of digits in entry.
overflow  output  1  sticky; set when a digit arrives with digit_count==DIGITS.
value  output  4*DIGITS  entry captured on the last enter.
value_valid  output  1  one-cycle pulse when value updates.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, debounce counter=0, candidate=0, and all outputs are 0. Reset mid-press aborts the press with no strobe. After release of reset, a key still held must pass the full debounce before it is accepted.
- The FSM advances only on clock edges where tick=1. Between ticks, state and counter hold.
- IDLE: on a sampled code other than none, capture candidate, set count=1, and go to CONFIRM.
- CONFIRM:
  - sampled code==candidate: count+1. When count reaches DEBOUNCE_TICKS, go to PRESSED and register press_strobe=1 with press_code=candidate for the following cycle only.
  - sampled code==none, or a different key: return to IDLE and set count=0. No strobe.
- PRESSED: sampled none sets count=1 and goes to RELEASE. Any key code (including a different one) stays in PRESSED; a key change while held never produces a strobe.
- RELEASE:
  - sampled none: count+1. When count reaches DEBOUNCE_TICKS, go to IDLE.
  - any key: return to PRESSED and set count=0.
- Press latency: press_strobe is high in the cycle immediately after the DEBOUNCE_TICKS-th matching tick edge.
- Entry update happens on the same edge press_strobe is registered, so entry, value and flags change together with the strobe:
  - Digit (code not CLEAR_CODE or ENTER_CODE, i.e. 0-13):
    - if digit_count<DIGITS: entry={entry[4*DIGITS-5:0], code} and digit_count+1.
    - else: entry and digit_count unchanged and overflow=1.
  - CLEAR_CODE: entry=0, digit_count=0, overflow=0. value is untouched.
  - ENTER_CODE with digit_count>0: value=entry, value_valid=1 for one cycle, then entry=0, digit_count=0, overflow=0.
  - ENTER_CODE with digit_count==0: ignored. No value_valid; value is unchanged.
- Widths: digit codes are truncated to 4 bits. No arithmetic on entry beyond shift/insert.
- A tick held high on consecutive cycles is legal; each such cycle counts as one sample.

Test Plan:
- Clean press: key_code=5 for 4 ticks, then 16 for 4 ticks -> single press_strobe with press_code=5, entry=0x0005, digit_count=1. State returns to IDLE after the 4th release tick.
- Bounce reject: key_code sequence 7,16,7,7,16 on ticks -> no press_strobe, entry unchanged. Then 7 for 4 ticks -> exactly one strobe with code 7.
- Release bounce: hold 3 (accepted), then samples 16,16,3,16,16,16,16 -> only one strobe total, no second press.
- Entry and enter: press 1,2,3,10 then 15 -> entry=0x123A before enter. On enter: value=0x123A, one-cycle value_valid, entry=0, digit_count=0.
- Overflow and clear: press 1,2,3,4,5 -> entry=0x1234 and overflow=1. Press 14 -> entry=0, overflow=0, value unchanged. Press 15 with no digits -> no value_valid.
- Reset mid-operation: assert reset_n=0 during CONFIRM with key 9 held, then deassert while 9 is still held -> all outputs 0 immediately. Strobe appears only after 4 fresh matching ticks post-reset.
